// File: rtl/passcode_lock_pkg.sv
// Shared types and constants for the passcode lock core (package passcode_pkg).
package passcode_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] MAX_DIGIT = 4'd9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPEN    = 2'd1,
    SET     = 2'd2,
    LOCKOUT = 2'd3
  } state_e;

endpackage

// File: rtl/passcode_lock_if.sv
// Key-pulse inputs and status outputs of the passcode lock, bundled as one port.
interface passcode_lock_if #(
  parameter int DIGITS = 4
);
  import passcode_pkg::*;

  logic                    digit_vld;
  logic [BCD_W-1:0]        digit;
  logic                    enter;
  logic                    clear;
  logic                    set_new;
  logic                    close;
  logic [DIGITS*BCD_W-1:0] entry;
  logic [3:0]              entry_cnt;
  logic                    unlocked;
  logic                    setting;
  logic                    alarm;
  logic [3:0]              tries_left;

  modport master (
    output digit_vld, digit, enter, clear, set_new, close,
    input  entry, entry_cnt, unlocked, setting, alarm, tries_left
  );

  modport slave (
    input  digit_vld, digit, enter, clear, set_new, close,
    output entry, entry_cnt, unlocked, setting, alarm, tries_left
  );

endinterface

// File: rtl/passcode_lock_lockout_timer.sv
// Lockout down-counter: load LOCK_CYCLES-1, count to zero, flag done while active.
module lockout_timer #(
  parameter int unsigned LOCK_CYCLES = 62_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LOCK_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The last LOCKOUT cycle is the one where the counter already reads zero.
  assign done = en && (cnt_q == '0);

endmodule

// File: rtl/passcode_lock.sv
// N-digit BCD passcode check with changeable code and failed-attempt counting.
// Timed lockout is built only when PASSCODE_LOCKOUT_EN is defined.
module passcode_lock
  import passcode_pkg::*;
#(
  parameter int unsigned               DIGITS      = 4,
  parameter logic [DIGITS*BCD_W-1:0]   ORIGIN_CODE = 16'h2580,
  parameter int unsigned               MAX_TRIES   = 3,
  parameter int unsigned               LOCK_CYCLES = 62_500_000
) (
  input  logic          clk,
  input  logic          rst,
  passcode_lock_if.slave bus
);

  localparam int         ENTRY_W     = DIGITS * BCD_W;
  localparam logic [3:0] DIGITS_C    = 4'(DIGITS);
  localparam logic [3:0] MAX_TRIES_C = 4'(MAX_TRIES);

  state_e               state_q, state_d;
  logic [ENTRY_W-1:0]   entry_q, entry_d;
  logic [3:0]           entry_cnt_q, entry_cnt_d;
  logic [ENTRY_W-1:0]   code_q, code_d;
  logic [3:0]           tries_q, tries_d;
  logic                 entry_full;
  logic                 code_match;
  logic                 digit_ok;

`ifdef PASSCODE_LOCKOUT_EN
  logic timer_load;
  logic timer_done;

  lockout_timer #(
    .LOCK_CYCLES(LOCK_CYCLES)
  ) u_lockout_timer (
    .clk (clk),
    .rst (rst),
    .load(timer_load),
    .en  (state_q == LOCKOUT),
    .done(timer_done)
  );
`endif

  assign entry_full = (entry_cnt_q == DIGITS_C);
  assign code_match = entry_full && (entry_q == code_q);
  assign digit_ok   = (bus.digit <= MAX_DIGIT) && (entry_cnt_q < DIGITS_C);

  always_comb begin
    state_d     = state_q;
    entry_d     = entry_q;
    entry_cnt_d = entry_cnt_q;
    code_d      = code_q;
    tries_d     = tries_q;
`ifdef PASSCODE_LOCKOUT_EN
    timer_load  = 1'b0;
`endif
    case (state_q)
      IDLE, SET: begin
        if (state_q == SET && bus.close) begin
          state_d     = IDLE;
          entry_d     = '0;
          entry_cnt_d = '0;
        end else if (bus.clear) begin
          entry_d     = '0;
          entry_cnt_d = '0;
        end else if (bus.enter) begin
          entry_d     = '0;
          entry_cnt_d = '0;
          if (state_q == SET) begin
            if (entry_full) begin
              code_d  = entry_q;
              state_d = OPEN;
            end
          end else if (code_match) begin
            state_d = OPEN;
            tries_d = MAX_TRIES_C;
          end else begin
`ifdef PASSCODE_LOCKOUT_EN
            tries_d = tries_q - 4'd1;
            if (tries_d == 4'd0) begin
              state_d    = LOCKOUT;
              timer_load = 1'b1;
            end
`else
            // Without lockout the counter just bottoms out at zero.
            if (tries_q != 4'd0) begin
              tries_d = tries_q - 4'd1;
            end
`endif
          end
        end else if (bus.digit_vld && digit_ok) begin
          entry_d     = ENTRY_W'({entry_q, bus.digit});
          entry_cnt_d = entry_cnt_q + 4'd1;
        end
      end
      OPEN: begin
        if (bus.set_new) begin
          state_d     = SET;
          entry_d     = '0;
          entry_cnt_d = '0;
        end else if (bus.close) begin
          state_d = IDLE;
        end
      end
      LOCKOUT: begin
`ifdef PASSCODE_LOCKOUT_EN
        if (timer_done) begin
          state_d = IDLE;
          tries_d = MAX_TRIES_C;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      entry_q     <= '0;
      entry_cnt_q <= '0;
      code_q      <= ORIGIN_CODE;
      tries_q     <= MAX_TRIES_C;
    end else begin
      state_q     <= state_d;
      entry_q     <= entry_d;
      entry_cnt_q <= entry_cnt_d;
      code_q      <= code_d;
      tries_q     <= tries_d;
    end
  end

  assign bus.entry      = entry_q;
  assign bus.entry_cnt  = entry_cnt_q;
  assign bus.unlocked   = (state_q == OPEN);
  assign bus.setting    = (state_q == SET);
  assign bus.tries_left = tries_q;
`ifdef PASSCODE_LOCKOUT_EN
  assign bus.alarm      = (state_q == LOCKOUT);
`else
  assign bus.alarm      = 1'b0;
`endif

endmodule
